// File: rtl/argmax_classifier.sv
// Argmax over a signed score vector, scanning one element per cycle; result held under valid/ready.
// Optional macro ARGMAX_MARGIN_EN adds out_margin (best minus runner-up score).
module argmax_classifier #(
    parameter  int BitSize    = 32,
    parameter  int NumClasses = 2,
    parameter  int CountBits  = 8,
    localparam int IdxBits    = (NumClasses > 1) ? $clog2(NumClasses) : 1
) (
    input  logic                                clk,
    input  logic                                res_n,
    input  logic                                in_valid,
    input  logic [NumClasses-1:0][BitSize-1:0]  in_data,
    input  logic                                in_done,
    output logic                                in_ready,
    output logic                                out_valid,
    output logic [IdxBits-1:0]                  out_class,
    output logic [BitSize-1:0]                  out_score,
    input  logic                                out_ready,
    output logic [CountBits-1:0]                out_count,
    output logic                                out_done,
`ifdef ARGMAX_MARGIN_EN
    output logic [BitSize:0]                    out_margin,
`endif
    output logic [1:0]                          dbg_state
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    // in_ready is high only in IDLE; out_valid is high only in HOLD, where the result stays frozen.
    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, HOLD = 2'd2} state_t;

    localparam logic [IdxBits-1:0] LastIdx = IdxBits'(NumClasses - 1);

    state_t                               state_q, state_d;
    logic [NumClasses-1:0][BitSize-1:0]   buf_q, buf_d;
    logic [BitSize-1:0]                   best_q, best_d;
    logic [IdxBits-1:0]                   best_idx_q, best_idx_d;
    logic [IdxBits-1:0]                   idx_q, idx_d;
    logic                                 done_pend_q, done_pend_d;
    logic [CountBits-1:0]                 count_q, count_d;
    logic                                 done_q, done_d;
    logic [IdxBits-1:0]                   res_class_q, res_class_d;
    logic [BitSize-1:0]                   res_score_q, res_score_d;
    logic [BitSize-1:0]                   elem;
`ifdef ARGMAX_MARGIN_EN
    localparam logic [BitSize-1:0] MostNeg = {1'b1, {(BitSize-1){1'b0}}};
    logic [BitSize-1:0]                   second_q, second_d;
    logic [BitSize:0]                     res_margin_q, res_margin_d;
`endif

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        best_d      = best_q;
        best_idx_d  = best_idx_q;
        idx_d       = idx_q;
        done_pend_d = done_pend_q;
        count_d     = count_q;
        done_d      = done_q;
        res_class_d = res_class_q;
        res_score_d = res_score_q;
`ifdef ARGMAX_MARGIN_EN
        second_d     = second_q;
        res_margin_d = res_margin_q;
`endif
        elem = buf_q[idx_q];
        unique case (state_q)
            IDLE: begin
                if (in_done && !in_valid) done_d = 1'b1;
                if (in_valid) begin
                    buf_d       = in_data;
                    best_d      = in_data[0];
                    best_idx_d  = '0;
                    idx_d       = IdxBits'(1);
                    done_pend_d = in_done;
`ifdef ARGMAX_MARGIN_EN
                    second_d = MostNeg;
`endif
                    if (NumClasses == 1) begin
                        // A single class is its own winner; no scan needed.
                        state_d     = HOLD;
                        res_class_d = '0;
                        res_score_d = in_data[0];
`ifdef ARGMAX_MARGIN_EN
                        res_margin_d = '0;
`endif
                    end else begin
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
                // Strict compare keeps the lowest index on ties.
                if ($signed(elem) > $signed(best_q)) begin
`ifdef ARGMAX_MARGIN_EN
                    second_d = best_q;
`endif
                    best_d     = elem;
                    best_idx_d = idx_q;
                end
`ifdef ARGMAX_MARGIN_EN
                else if ($signed(elem) > $signed(second_q)) begin
                    second_d = elem;
                end
`endif
                idx_d = idx_q + IdxBits'(1);
                if (idx_q == LastIdx) begin
                    state_d     = HOLD;
                    res_class_d = best_idx_d;
                    res_score_d = best_d;
`ifdef ARGMAX_MARGIN_EN
                    res_margin_d = {best_d[BitSize-1], best_d} - {second_d[BitSize-1], second_d};
`endif
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                    count_d = count_q + CountBits'(1);
                    if (done_pend_q) done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            state_q     <= IDLE;
            buf_q       <= '0;
            best_q      <= '0;
            best_idx_q  <= '0;
            idx_q       <= '0;
            done_pend_q <= 1'b0;
            count_q     <= '0;
            done_q      <= 1'b0;
            res_class_q <= '0;
            res_score_q <= '0;
`ifdef ARGMAX_MARGIN_EN
            second_q     <= '0;
            res_margin_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            best_q      <= best_d;
            best_idx_q  <= best_idx_d;
            idx_q       <= idx_d;
            done_pend_q <= done_pend_d;
            count_q     <= count_d;
            done_q      <= done_d;
            res_class_q <= res_class_d;
            res_score_q <= res_score_d;
`ifdef ARGMAX_MARGIN_EN
            second_q     <= second_d;
            res_margin_q <= res_margin_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign out_class = res_class_q;
    assign out_score = res_score_q;
    assign out_count = count_q;
    assign out_done  = done_q;
    assign dbg_state = state_q;
`ifdef ARGMAX_MARGIN_EN
    assign out_margin = res_margin_q;
`endif

endmodule
